multicycle_timing_gen: RTL and testbench

Parametrised stage sequencer for the multicycle RISC core. It supersedes the fixed 3-bit stage counter with a configurable counter width and stage limit, and adds run/idle control, stall, flush and a one-hot stage bus. It also detects stage overrun and generates an instruction-completion strobe. It sits between the control decoder, which supplies `last_stage`, and the datapath enables, which consume `stage_onehot`.

---
 rtl/multicycle_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_multicycle_timing_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_timing_gen.sv
// multicycle_timing_gen: stage sequencer for the multicycle RISC core.
// Walks Cnt through 0..MAX_STAGES-1 while in RUN. It retires an instruction
// on last_stage, treats running off the final legal stage as an overrun, and
// drives a one-hot stage bus for the datapath enables.
// Optional feature macro: TIMING_PERF_EN adds the cyc_count/ret_count
// performance counters.
module multicycle_timing_gen #(
    parameter int CNT_W        = 3,
    parameter int MAX_STAGES   = 5,
    parameter int OVERRUN_STOP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  last_stage,
    input  logic                  clr_fault,
    output logic [CNT_W-1:0]      Cnt,
    output logic [MAX_STAGES-1:0] stage_onehot,
    output logic                  instr_done,
    output logic                  overrun,
    output logic [1:0]            state
`ifdef TIMING_PERF_EN
    ,
    output logic [31:0]           cyc_count,
    output logic [31:0]           ret_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    // Index of the final legal stage; Cnt never goes past it.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_STAGES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             instr_done_q, instr_done_d;
    logic             overrun_q, overrun_d;

    // State register: asynchronous reset, all core state updates on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            instr_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            instr_done_q <= instr_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state logic: RUN rules are evaluated in priority flush > stall > last_stage > overrun > advance.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        instr_done_d = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (clr_fault) overrun_d = 1'b0;
                if (run) state_d = ST_RUN;
            end

            ST_RUN: begin
                if (flush) begin
                    // Abort without retiring; this is an instruction boundary.
                    cnt_d = '0;
                    if (clr_fault) overrun_d = 1'b0;
                    if (!run) state_d = ST_IDLE;
                end else if (stall) begin
                    // Freeze stage, state and overrun; retirement waits.
                    cnt_d = cnt_q;
                end else if (last_stage) begin
                    cnt_d        = '0;
                    instr_done_d = 1'b1;
                    if (clr_fault) overrun_d = 1'b0;
                    if (!run) state_d = ST_IDLE;
                end else if (cnt_q == LAST_IDX) begin
                    // Ran off the final stage without the decoder ending the
                    // instruction: retire it anyway and flag the error. The
                    // set takes precedence over a simultaneous clr_fault.
                    cnt_d        = '0;
                    instr_done_d = 1'b1;
                    overrun_d    = 1'b1;
                    if (OVERRUN_STOP != 0) begin
                        state_d = ST_FAULT;
                    end else if (!run) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (clr_fault) overrun_d = 1'b0;
                end
            end

            ST_FAULT: begin
                cnt_d = '0;
                if (clr_fault) begin
                    state_d   = ST_IDLE;
                    overrun_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: one-hot stage bus, active only while running.
    always_comb begin
        stage_onehot = '0;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < MAX_STAGES; i++) begin
                if (cnt_q == CNT_W'(i)) stage_onehot[i] = 1'b1;
            end
        end
    end

    assign Cnt        = cnt_q;
    assign state      = state_q;
    assign instr_done = instr_done_q;
    assign overrun    = overrun_q;

`ifdef TIMING_PERF_EN
    logic [31:0] cyc_count_q, cyc_count_d;
    logic [31:0] ret_count_q, ret_count_d;

    // Performance counter next values: RUN cycles (stalls included) and retirements, wrapping mod 2^32.
    always_comb begin
        cyc_count_d = cyc_count_q + ((state_q == ST_RUN) ? 32'd1 : 32'd0);
        ret_count_d = ret_count_q + (instr_done_d ? 32'd1 : 32'd0);
    end

    // Performance counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_count_q <= '0;
            ret_count_q <= '0;
        end else begin
            cyc_count_q <= cyc_count_d;
            ret_count_q <= ret_count_d;
        end
    end

    assign cyc_count = cyc_count_q;
    assign ret_count = ret_count_q;
`endif

endmodule

// File: tb/tb_multicycle_timing_gen.sv
// Testbench for multicycle_timing_gen. Two instances share one stimulus
// stream: one wraps on overrun and one stops in FAULT. Each is compared every
// cycle against a behavioural model of the stage sequencing rules.
// The directed steps are followed by randomized traffic.
module tb_multicycle_timing_gen;

    localparam int CNT_W      = 3;
    localparam int MAX_STAGES = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic clk = 1'b0;
    logic rst, run, stall, flush, last_stage, clr_fault;

    logic [CNT_W-1:0]      cnt_w, cnt_s;
    logic [MAX_STAGES-1:0] oh_w, oh_s;
    logic                  done_w, done_s, ovr_w, ovr_s;
    logic [1:0]            st_w, st_s;
`ifdef TIMING_PERF_EN
    logic [31:0]           cyc_w, ret_w, cyc_s, ret_s;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_timing_gen #(
        .CNT_W(CNT_W), .MAX_STAGES(MAX_STAGES), .OVERRUN_STOP(0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .run(run), .stall(stall), .flush(flush),
        .last_stage(last_stage), .clr_fault(clr_fault),
        .Cnt(cnt_w), .stage_onehot(oh_w), .instr_done(done_w),
        .overrun(ovr_w), .state(st_w)
`ifdef TIMING_PERF_EN
        , .cyc_count(cyc_w), .ret_count(ret_w)
`endif
    );

    multicycle_timing_gen #(
        .CNT_W(CNT_W), .MAX_STAGES(MAX_STAGES), .OVERRUN_STOP(1)
    ) dut_stop (
        .clk(clk), .rst(rst), .run(run), .stall(stall), .flush(flush),
        .last_stage(last_stage), .clr_fault(clr_fault),
        .Cnt(cnt_s), .stage_onehot(oh_s), .instr_done(done_s),
        .overrun(ovr_s), .state(st_s)
`ifdef TIMING_PERF_EN
        , .cyc_count(cyc_s), .ret_count(ret_s)
`endif
    );

    // Behavioural model: mode, stage number, pulse, sticky flag, counters.
    typedef struct {
        int          mode;
        int          cnt;
        bit          done;
        bit          ovr;
        int unsigned cyc;
        int unsigned ret;
    } model_t;

    model_t mw, ms;

    function automatic model_t model_reset();
        model_t m;
        m.mode = M_IDLE; m.cnt = 0; m.done = 0; m.ovr = 0; m.cyc = 0; m.ret = 0;
        return m;
    endfunction

    // One clock edge of the sequencing rules applied to the current inputs.
    function automatic model_t model_next(model_t m, bit stop);
        model_t n;
        bit     at_end, retire, over;
        n      = m;
        n.done = 0;
        if (m.mode == M_IDLE) begin
            n.cnt = 0;
            if (clr_fault) n.ovr = 0;
            if (run) n.mode = M_RUN;
        end else if (m.mode == M_FAULT) begin
            n.cnt = 0;
            if (clr_fault) begin n.mode = M_IDLE; n.ovr = 0; end
        end else begin
            n.cyc = m.cyc + 1;
            if (flush) begin
                n.cnt = 0;
                if (clr_fault) n.ovr = 0;
                if (!run) n.mode = M_IDLE;
            end else if (!stall) begin
                at_end = (m.cnt == MAX_STAGES - 1);
                retire = last_stage || at_end;
                over   = !last_stage && at_end;
                if (clr_fault) n.ovr = 0;
                if (over) n.ovr = 1;
                if (retire) begin
                    n.cnt  = 0;
                    n.done = 1;
                    n.ret  = m.ret + 1;
                    if (over && stop) n.mode = M_FAULT;
                    else if (!run)    n.mode = M_IDLE;
                end else begin
                    n.cnt = m.cnt + 1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [MAX_STAGES-1:0] exp_onehot(model_t m);
        logic [MAX_STAGES-1:0] v;
        v = '0;
        if (m.mode == M_RUN) v[m.cnt] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".w.cnt"},   64'(cnt_w),  64'(mw.cnt));
        check({tag, ".w.state"}, 64'(st_w),   64'(mw.mode));
        check({tag, ".w.oh"},    64'(oh_w),   64'(exp_onehot(mw)));
        check({tag, ".w.done"},  64'(done_w), 64'(mw.done));
        check({tag, ".w.ovr"},   64'(ovr_w),  64'(mw.ovr));
        check({tag, ".s.cnt"},   64'(cnt_s),  64'(ms.cnt));
        check({tag, ".s.state"}, 64'(st_s),   64'(ms.mode));
        check({tag, ".s.oh"},    64'(oh_s),   64'(exp_onehot(ms)));
        check({tag, ".s.done"},  64'(done_s), 64'(ms.done));
        check({tag, ".s.ovr"},   64'(ovr_s),  64'(ms.ovr));
`ifdef TIMING_PERF_EN
        check({tag, ".w.cyc"},   64'(cyc_w),  64'(mw.cyc));
        check({tag, ".w.ret"},   64'(ret_w),  64'(mw.ret));
        check({tag, ".s.cyc"},   64'(cyc_s),  64'(ms.cyc));
        check({tag, ".s.ret"},   64'(ret_s),  64'(ms.ret));
`endif
    endtask

    // Advance one edge, update the model, then sample 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        mw = model_next(mw, 1'b0);
        ms = model_next(ms, 1'b1);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int done_seen;

        // Reset with run already high.
        rst = 1'b1; run = 1'b1; stall = 1'b0; flush = 1'b0;
        last_stage = 1'b0; clr_fault = 1'b0;
        mw = model_reset();
        ms = model_reset();
        #12;
        compare_all("reset");
        check("reset.state_lit", 64'(st_w), 64'd0);
        rst = 1'b0;

        // Test 1: stages 0..3, last_stage at Cnt=3.
        for (int i = 0; i < 6; i++) begin
            last_stage = (mw.mode == M_RUN) && (mw.cnt == 3);
            cycle("t1");
        end
        last_stage = 1'b0;

        // Test 2: stall three cycles at Cnt=2, then finish at Cnt=4.
        for (int i = 0; i < 8 && mw.cnt != 2; i++) cycle("t2.seek");
        check("t2.at2", 64'(cnt_w), 64'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("t2.stall");
            check("t2.hold", 64'(cnt_w), 64'd2);
        end
        stall = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            last_stage = (mw.cnt == 4);
            cycle("t2.run");
            done_seen += int'(done_w);
        end
        last_stage = 1'b0;
        check("t2.cnt0", 64'(cnt_w), 64'd0);
        check("t2.one_done", 64'(done_seen), 64'd1);

        // Test 3: flush together with last_stage at Cnt=2.
        for (int i = 0; i < 8 && mw.cnt != 2; i++) cycle("t3.seek");
        flush = 1'b1; last_stage = 1'b1;
        cycle("t3.flush");
        check("t3.cnt", 64'(cnt_w), 64'd0);
        check("t3.nodone", 64'(done_w), 64'd0);
        check("t3.state", 64'(st_w), 64'd1);
        flush = 1'b0; last_stage = 1'b0;

        // Test 4: no last_stage; overrun after Cnt=4.
        for (int i = 0; i < 5; i++) cycle("t4.walk");
        check("t4.s.state", 64'(st_s), 64'b10);
        check("t4.s.ovr", 64'(ovr_s), 64'd1);
        check("t4.s.oh", 64'(oh_s), 64'd0);
        check("t4.s.done", 64'(done_s), 64'd1);
        check("t4.w.state", 64'(st_w), 64'd1);
        cycle("t4.fault");
        check("t4.s.done_off", 64'(done_s), 64'd0);
        clr_fault = 1'b1;
        cycle("t4.clr");
        check("t4.s.idle", 64'(st_s), 64'd0);
        check("t4.s.ovr_clr", 64'(ovr_s), 64'd0);
        clr_fault = 1'b0;

        // Test 5: drop run at Cnt=1, retire at Cnt=3, then resume.
        for (int i = 0; i < 8 && mw.cnt != 1; i++) cycle("t5.seek");
        run = 1'b0;
        for (int i = 0; i < 8 && mw.mode != M_IDLE; i++) begin
            last_stage = (mw.cnt == 3);
            cycle("t5.drain");
        end
        last_stage = 1'b0;
        check("t5.idle", 64'(st_w), 64'd0);
        check("t5.cnt", 64'(cnt_w), 64'd0);
        cycle("t5.idle_hold");
        run = 1'b1;
        cycle("t5.resume");
        check("t5.run", 64'(st_w), 64'd1);
        check("t5.stage0", 64'(oh_w), 64'd1);

        // Test 6: asynchronous reset between edges at Cnt=3.
        for (int i = 0; i < 8 && mw.cnt != 3; i++) cycle("t6.seek");
        check("t6.at3", 64'(cnt_w), 64'd3);
        #2 rst = 1'b1;
        mw = model_reset();
        ms = model_reset();
        #1;
        compare_all("t6.rst");
        check("t6.cnt", 64'(cnt_w), 64'd0);
        check("t6.nodone", 64'(done_w), 64'd0);
`ifdef TIMING_PERF_EN
        check("t6.cyc0", 64'(cyc_w), 64'd0);
        check("t6.ret0", 64'(ret_w), 64'd0);
`endif
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            run        = ($urandom_range(0, 9) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            last_stage = ($urandom_range(0, 3) == 0);
            clr_fault  = ($urandom_range(0, 11) == 0);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
